// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared types for the forwarding/hazard unit.
// Feature macro FWD_WB_BYPASS_EN adds a WB-to-ID bypass path.
package fwd_pkg;

   localparam int AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN,
      LDUSE,
      MEMWAIT
   } hz_state_t;

   typedef logic [AW-1:0] regbits_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - pipeline-side bundle of the forwarding/hazard unit.
// Feature macro FWD_WB_BYPASS_EN adds wb_rd, wb_regwr and id_bypass.
interface fwd_hazard_unit_if #(
   parameter int NREAD = 2,
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic [NREAD*AW-1:0] id_src;
   logic [NREAD-1:0]    id_src_en;
   logic [AW-1:0]       ex_rd;
   logic                ex_regwr;
   logic                ex_memread;
   logic [AW-1:0]       mem_rd;
   logic                mem_regwr;
   logic                mem_memread;
   logic                mem_dhit;
   logic                flush;
   logic [NREAD*2-1:0]  fwd_sel;
   logic                stall_id;
   logic                freeze_all;
   logic [CNT_W-1:0]    stall_cnt;
`ifdef FWD_WB_BYPASS_EN
   logic [AW-1:0]       wb_rd;
   logic                wb_regwr;
   logic [NREAD-1:0]    id_bypass;
`endif

   modport master (
      output id_src, id_src_en, ex_rd, ex_regwr, ex_memread,
      output mem_rd, mem_regwr, mem_memread, mem_dhit, flush,
`ifdef FWD_WB_BYPASS_EN
      output wb_rd, wb_regwr,
      input  id_bypass,
`endif
      input  fwd_sel, stall_id, freeze_all, stall_cnt
   );

   modport slave (
      input  id_src, id_src_en, ex_rd, ex_regwr, ex_memread,
      input  mem_rd, mem_regwr, mem_memread, mem_dhit, flush,
`ifdef FWD_WB_BYPASS_EN
      input  wb_rd, wb_regwr,
      output id_bypass,
`endif
      output fwd_sel, stall_id, freeze_all, stall_cnt
   );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// rtl/fwd_hazard_unit_match.sv - per-operand producer compare and select priority.
// Feature macro FWD_WB_BYPASS_EN adds the WB compare output.
module fwd_match #(
   parameter int AW = 5
) (
   input  logic [AW-1:0] src_i,
   input  logic          en_i,
   input  logic [AW-1:0] ex_rd_i,
   input  logic          ex_regwr_i,
   input  logic [AW-1:0] mem_rd_i,
   input  logic          mem_regwr_i,
`ifdef FWD_WB_BYPASS_EN
   input  logic [AW-1:0] wb_rd_i,
   input  logic          wb_regwr_i,
   output logic          bypass_o,
`endif
   output logic [1:0]    sel_o,
   output logic          match_ex_o
);
   import fwd_pkg::*;

   logic     live;
   logic     match_mem;
   fwd_sel_t sel;

   // r0 is hard-wired zero, so a write to it never produces forwardable data
   assign live = en_i && (src_i != '0);

   always_comb begin
      match_ex_o = live && ex_regwr_i && (ex_rd_i == src_i);
      match_mem  = live && mem_regwr_i && (mem_rd_i == src_i);
      sel        = FWD_RF;
      if (match_ex_o) begin
         sel = FWD_MEM;
      end else if (match_mem) begin
         sel = FWD_WB;
      end
      sel_o = sel;
   end

`ifdef FWD_WB_BYPASS_EN
   assign bypass_o = live && wb_regwr_i && (wb_rd_i == src_i);
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - ID-stage forwarding resolve, load-use interlock, memory-wait freeze.
// Feature macro FWD_WB_BYPASS_EN enables id_bypass for a non-write-first regfile.
module fwd_hazard_unit #(
   parameter int NREAD = 2,
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input logic               CLK,
   input logic               RST,
   fwd_hazard_unit_if.slave  bus
);
   import fwd_pkg::*;

   hz_state_t          state_q, state_d;
   logic [NREAD*2-1:0] sel_next, sel_q, sel_d;
   logic [NREAD-1:0]   match_ex;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               load_use, mem_wait;
   logic               stall_id, freeze_all;
`ifdef FWD_WB_BYPASS_EN
   logic [NREAD-1:0]   bypass_raw;
`endif

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_op
      fwd_match #(.AW(AW)) u_match (
         .src_i       (bus.id_src[gi*AW +: AW]),
         .en_i        (bus.id_src_en[gi]),
         .ex_rd_i     (bus.ex_rd),
         .ex_regwr_i  (bus.ex_regwr),
         .mem_rd_i    (bus.mem_rd),
         .mem_regwr_i (bus.mem_regwr),
`ifdef FWD_WB_BYPASS_EN
         .wb_rd_i     (bus.wb_rd),
         .wb_regwr_i  (bus.wb_regwr),
         .bypass_o    (bypass_raw[gi]),
`endif
         .sel_o       (sel_next[gi*2 +: 2]),
         .match_ex_o  (match_ex[gi])
      );
   end

   assign load_use = bus.ex_memread && (|match_ex);
   assign mem_wait = bus.mem_memread && !bus.mem_dhit;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // A memory stall outranks the interlock; the interlock is re-evaluated from RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (mem_wait) begin
               state_d = MEMWAIT;
            end else if (load_use) begin
               state_d = LDUSE;
            end
         end
         LDUSE:   state_d = RUN;
         MEMWAIT: if (bus.mem_dhit) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      freeze_all = !RST && mem_wait;
      stall_id   = !RST && load_use && !mem_wait;
   end

   always_comb begin
      sel_d = sel_q;
      cnt_d = cnt_q;
      if (!freeze_all) begin
         sel_d = (bus.flush || stall_id) ? '0 : sel_next;
      end
      if ((stall_id || freeze_all) && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sel_q <= '0;
         cnt_q <= '0;
      end else begin
         sel_q <= sel_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.fwd_sel    = sel_q;
   assign bus.stall_id   = stall_id;
   assign bus.freeze_all = freeze_all;
   assign bus.stall_cnt  = cnt_q;
`ifdef FWD_WB_BYPASS_EN
   assign bus.id_bypass  = RST ? '0 : bypass_raw;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forward unit for the 5-stage pipeline.
- Generalises forwarding to NREAD source operands.
- Resolves forwarding at ID and registers the result into EX, so EX sees ready-made mux selects.
- Adds a load-use interlock, a data-memory-wait freeze FSM, and a saturating stall-cycle counter.

Parameters:
NREAD, 2, number of source operands per instruction (rs, rt, ...).
AW, 5, register address width.
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous active-high reset.
id_src  in  NREAD*AW  ID-stage source register numbers; operand i at [i*AW +: AW].
id_src_en  in  NREAD  operand i actually read by the ID instruction.
ex_rd  in  AW  destination register of the instruction in EX.
ex_regwr  in  1  EX instruction writes the register file.
ex_memread  in  1  EX instruction is a load.
mem_rd  in  AW  destination register of the instruction in MEM.
mem_regwr  in  1  MEM instruction writes the register file.
mem_memread  in  1  MEM instruction is a load.
mem_dhit  in  1  data memory completes this cycle.
flush  in  1  branch/jump flush of the ID/EX boundary.
fwd_sel  out  NREAD*2  EX-stage select per operand: 0 = regfile, 1 = EX/MEM latch, 2 = MEM/WB latch; 3 never driven.
stall_id  out  1  hold PC and IF/ID; insert bubble into EX.
freeze_all  out  1  hold every pipeline latch.
stall_cnt  out  CNT_W  saturating count of cycles with stall_id or freeze_all high.

Behaviour:
- FSM states:
  - RUN.
  - LDUSE: one-cycle bubble.
  - MEMWAIT.
- Reset (RST high on a rising edge):
  - state = RUN, fwd_sel = 0, stall_cnt = 0.
  - stall_id = 0 and freeze_all = 0 during the reset cycle.
- Match rules for operand i:
  - match_ex(i) = id_src_en[i] && ex_regwr && ex_rd == src_i && src_i != 0.
  - match_mem(i) is the same test using mem_rd and mem_regwr.
  - Register 0 never matches.
- Next select for operand i:
  - match_ex → 1; else match_mem → 2; else 0.
  - Nearest producer wins when both match.
- load_use = ex_memread && any match_ex(i).
- mem_wait = mem_memread && !mem_dhit.
- Transitions:
  - RUN → MEMWAIT if mem_wait. MEMWAIT has priority over load_use in the same cycle.
  - RUN → LDUSE if load_use.
  - LDUSE → RUN unconditionally. The producer is now in MEM, so the recomputed select is 2.
  - MEMWAIT → RUN when mem_dhit. If load_use still holds on exit, the next cycle evaluates it from RUN.
- Outputs (combinational from state and inputs):
  - freeze_all = mem_wait, in any state.
  - stall_id = load_use && !mem_wait.
- fwd_sel register update, evaluated in this order:
  - freeze_all → hold.
  - flush or stall_id → 0 (bubble carries no forwarding).
  - else → load next select.
  - flush has no effect during freeze_all.
- Latency: select computed in ID appears on fwd_sel the cycle the instruction occupies EX, which is one cycle later.
- stall_cnt increments when (stall_id || freeze_all) and not at all-ones; it saturates at all-ones.
- RST mid-stall returns to RUN immediately; the counter clears.

Optional Feature:
Macro FWD_WB_BYPASS_EN.
- Defined:
  - Extra inputs wb_rd (AW bits) and wb_regwr (1 bit).
  - Extra output id_bypass (NREAD bits).
  - id_bypass[i] = id_src_en[i] && wb_regwr && wb_rd == src_i && src_i != 0, combinational in the same cycle. It lets ID take WB data when the regfile is not write-first.
  - id_bypass is 0 during RST.
- Not defined: no extra ports; the regfile is write-first.

Decomposition:
- Package fwd_pkg:
  - typedef fwd_sel_t as a 2-bit enum: FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2.
  - typedef hz_state_t: RUN, LDUSE, MEMWAIT.
  - typedef regbits_t as logic [AW-1:0].
- Sub-module fwd_match: per-operand compare and priority encoder, instantiated NREAD times in a generate loop.

Test Plan:
- RAW on EX: ex_rd=8, ex_regwr=1, id_src0=8, en0=1 → next cycle fwd_sel[0]=1, stall_id never asserted.
- Double match: ex_rd=mem_rd=9, both regwr, id_src1=9 → fwd_sel[1]=1. Same with ex_regwr=0 → fwd_sel[1]=2.
- Load-use: ex_memread=1, ex_rd=4, id_src0=4 → stall_id=1 for 1 cycle, fwd_sel=0 next cycle. Then producer in MEM → fwd_sel[0]=2 the following cycle; stall_cnt=1.
- Register 0: ex_rd=0, ex_regwr=1, id_src0=0 → fwd_sel stays 0, no stall.
- Memory wait with pending load-use: mem_memread=1, mem_dhit=0 for 3 cycles while load_use true → freeze_all=1 and stall_id=0 for 3 cycles, fwd_sel held. Then one LDUSE cycle; stall_cnt=4.
- Flush and reset: flush=1 with a match → fwd_sel=0 next cycle. RST asserted in MEMWAIT → state RUN, stall_cnt=0 the next cycle. Counter preloaded near max → saturates at 2^CNT_W-1.
